// File: rtl/l2_icache_resp.sv
// -----------------------------------------------------------------------------
// l2_icache_resp
//
// L2 responder for L1 instruction-cache refills. A read request latches the
// line address, fetches the four 32-bit words of the line from memory one beat
// at a time, presents the assembled 128-bit line with a one-cycle l2_rdy
// strobe, and then stays busy until the L1 reports that the line has been
// written into its arrays. Write requests are illegal on this path: they set
// a sticky error flag and are otherwise dropped.
//
// Optional feature (macro): CRITICAL_WORD_FIRST_EN
//   defined   -> the first beat fetches the requested word l2_addr[3:2] and
//                the following beats wrap upwards (e.g. 2,3,0,1)
//   undefined -> beats are always fetched in word order 0,1,2,3
//   Either way each word lands in the slot given by its own word index.
//
// Ports
//   clk         in   1    clock, all state changes on the rising edge
//   reset       in   1    synchronous active-high reset
//   irq         in   1    refill request from the L1 controller
//   l2_addr     in   32   request byte address: [31:4] line, [3:2] word
//   l2_cache_rw in   1    request direction (`READ / `WRITE)
//   complete    in   1    L1 has written the refill line
//   l2_busy     out  1    responder occupied (every state except IDLE)
//   l2_rdy      out  1    one-cycle strobe, l2_rdata valid
//   l2_rdata    out  128  refill line, word w at [32w+31:32w]
//   wr_err      out  1    sticky, set by a `WRITE request
//   mem_req     out  1    memory beat request, held until mem_ack
//   mem_addr    out  32   beat address {line, beat_word, 2'b00}
//   mem_ack     in   1    beat accepted, mem_rdata valid in the same cycle
//   mem_rdata   in   32   beat read data
// -----------------------------------------------------------------------------

`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

module l2_icache_resp (
    input  logic         clk,
    input  logic         reset,
    input  logic         irq,
    input  logic [31:0]  l2_addr,
    input  logic         l2_cache_rw,
    input  logic         complete,
    output logic         l2_busy,
    output logic         l2_rdy,
    output logic [127:0] l2_rdata,
    output logic         wr_err,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        RDY      = 2'd2,
        WAIT_CMP = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;

    logic [27:0]    line_r;
    logic [1:0]     first_word_r;
    logic [1:0]     beat_cnt_r;

    logic           busy_r;
    logic           rdy_r;
    logic [127:0]   rdata_r;
    logic           wr_err_r;
    logic           mem_req_r;
    logic [31:0]    mem_addr_r;

    logic           accept_s;
    logic           wr_req_s;
    logic           beat_s;
    logic           last_beat_s;
    logic [1:0]     start_word_s;
    logic [1:0]     beat_word_s;
    logic [1:0]     next_word_s;
    logic [6:0]     slot_lsb_s;

    // Word fetched by the first beat of a newly accepted request.
    always_comb begin
        start_word_s = 2'b00;
`ifdef CRITICAL_WORD_FIRST_EN
        start_word_s = l2_addr[3:2];
`else
        start_word_s = 2'b00;
`endif
    end

    // Beat word bookkeeping; 2-bit adds wrap 3->0 naturally.
    always_comb begin
        beat_word_s = first_word_r + beat_cnt_r;
        next_word_s = first_word_r + beat_cnt_r + 2'd1;
        slot_lsb_s  = {beat_word_s, 5'b00000};
        beat_s      = (state_r == FETCH) && mem_ack;
        last_beat_s = beat_s && (beat_cnt_r == 2'd3);
    end

    // Next-state logic and request decode.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        wr_req_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (irq) begin
                    if (l2_cache_rw == `READ) begin
                        state_s  = FETCH;
                        accept_s = 1'b1;
                    end else begin
                        state_s  = IDLE;
                        wr_req_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (last_beat_s) begin
                    state_s = RDY;
                end else begin
                    state_s = FETCH;
                end
            end
            RDY: begin
                if (complete) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_CMP;
                end
            end
            WAIT_CMP: begin
                if (complete) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_CMP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs. The strobe-style outputs are
    // registered from the next state so they line up with the state they
    // describe, e.g. mem_req drops in the same cycle RDY is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            line_r       <= 28'd0;
            first_word_r <= 2'd0;
            beat_cnt_r   <= 2'd0;
            busy_r       <= 1'b0;
            rdy_r        <= 1'b0;
            rdata_r      <= 128'd0;
            wr_err_r     <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= 32'd0;
        end else begin
            state_r   <= state_s;
            busy_r    <= (state_s != IDLE);
            rdy_r     <= (state_s == RDY);
            mem_req_r <= (state_s == FETCH);
            if (wr_req_s) begin
                wr_err_r <= 1'b1;
            end
            if (accept_s) begin
                line_r       <= l2_addr[31:4];
                first_word_r <= start_word_s;
                beat_cnt_r   <= 2'd0;
                mem_addr_r   <= {l2_addr[31:4], start_word_s, 2'b00};
            end else if (beat_s) begin
                rdata_r[slot_lsb_s +: 32] <= mem_rdata;
                beat_cnt_r                <= beat_cnt_r + 2'd1;
                // After the last beat the address simply holds; mem_req is low.
                if (!last_beat_s) begin
                    mem_addr_r <= {line_r, next_word_s, 2'b00};
                end
            end
        end
    end

    assign l2_busy  = busy_r;
    assign l2_rdy   = rdy_r;
    assign l2_rdata = rdata_r;
    assign wr_err   = wr_err_r;
    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;

endmodule

// File: tb/tb_l2_icache_resp.sv
`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

module tb_l2_icache_resp;

    logic         clk;
    logic         reset;
    logic         irq;
    logic [31:0]  l2_addr;
    logic         l2_cache_rw;
    logic         complete;
    logic         l2_busy;
    logic         l2_rdy;
    logic [127:0] l2_rdata;
    logic         wr_err;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    logic         ack_allow;
    logic         ack_force;

    int checks;
    int errors;
    int cyc;
    int accept_cyc;
    int exp_lat;

    logic [31:0]  exp_addr_q[$];
    logic [127:0] exp_line_q[$];

    l2_icache_resp dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .l2_addr     (l2_addr),
        .l2_cache_rw (l2_cache_rw),
        .complete    (complete),
        .l2_busy     (l2_busy),
        .l2_rdy      (l2_rdy),
        .l2_rdata    (l2_rdata),
        .wr_err      (wr_err),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word data low byte is 0xA0 + word index, upper bits carry the line.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[27:4], 6'b101000, a[3:2]};
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) begin
            l[32*w +: 32] = mem_word({a[31:4], w[1:0], 2'b00});
        end
        return l;
    endfunction

    assign mem_rdata = mem_word(mem_addr);
    assign mem_ack   = ack_force | (mem_req & ack_allow);

    // Scoreboard monitor: beats and refill lines are popped as the DUT produces them.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && mem_ack) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: mem_addr=%h, no beat expected", mem_addr);
                end else begin
                    logic [31:0] ea;
                    ea = exp_addr_q.pop_front();
                    if (mem_addr !== ea) begin
                        errors++;
                        $display("FAIL beat_addr: got %h expected %h", mem_addr, ea);
                    end
                end
            end
            if (l2_rdy) begin
                checks++;
                if (exp_line_q.size() == 0) begin
                    errors++;
                    $display("FAIL rdy_unexpected: l2_rdata=%h", l2_rdata);
                end else begin
                    logic [127:0] el;
                    el = exp_line_q.pop_front();
                    if (l2_rdata !== el) begin
                        errors++;
                        $display("FAIL line_data: got %h expected %h", l2_rdata, el);
                    end
                end
                // Latency counted inclusively from the accept cycle to the l2_rdy cycle.
                checks++;
                if ((cyc - accept_cyc + 1) !== exp_lat) begin
                    errors++;
                    $display("FAIL rdy_latency: got %0d expected %0d", cyc - accept_cyc + 1, exp_lat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a read in the current (IDLE) cycle and push its expectations.
    task automatic issue_read(input logic [31:0] a);
        logic [1:0] w0;
        w0 = 2'b00;
`ifdef CRITICAL_WORD_FIRST_EN
        w0 = a[3:2];
`endif
        for (int i = 0; i < 4; i++) begin
            logic [1:0] w;
            w = w0 + i[1:0];
            exp_addr_q.push_back({a[31:4], w, 2'b00});
        end
        exp_line_q.push_back(line_of(a));
        irq         = 1'b1;
        l2_cache_rw = `READ;
        l2_addr     = a;
        accept_cyc  = cyc;
        exp_lat     = 6;
        tick();
        irq = 1'b0;
    endtask

    task automatic wait_rdy(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (l2_rdy) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_rdy_timeout: l2_rdy=0 after 60 cycles, required 1", tag);
        end
    endtask

    task automatic finish_req(input string tag, input logic [127:0] line);
        complete = 1'b1;
        tick();
        complete = 1'b0;
        checks++;
        if (l2_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after_complete: got %b expected 0", tag, l2_busy);
        end
        checks++;
        if (l2_rdata !== line) begin
            errors++;
            $display("FAIL %s_rdata_hold: got %h expected %h", tag, l2_rdata, line);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({l2_busy, l2_rdy, mem_req, wr_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/rdy/req/err=%b expected 0000", {l2_busy, l2_rdy, mem_req, wr_err});
        end
        checks++;
        if (mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem_addr: got %h expected 0", mem_addr);
        end
        checks++;
        if (l2_rdata !== 128'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", l2_rdata);
        end
    endtask

    // Basic read, delayed complete with an ignored irq, then accept on the first IDLE cycle.
    task automatic test_read_and_delayed_complete();
        logic [31:0] a1;
        logic [31:0] a2;
        a1 = 32'h0000_1238;
        a2 = 32'hDEAD_BEE7;
        issue_read(a1);
        checks++;
        if ({mem_req, l2_busy} !== 2'b11) begin
            errors++;
            $display("FAIL first_fetch_cycle: req/busy=%b expected 11", {mem_req, l2_busy});
        end
        wait_rdy("basic");
        checks++;
        if ({mem_req, l2_busy} !== 2'b01) begin
            errors++;
            $display("FAIL rdy_cycle: req/busy=%b expected 01", {mem_req, l2_busy});
        end
        irq         = 1'b1;
        l2_cache_rw = `READ;
        l2_addr     = 32'h0000_7770;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({l2_busy, l2_rdy, mem_req} !== 3'b100) begin
                errors++;
                $display("FAIL wait_cmp_%0d: busy/rdy/req=%b expected 100", i, {l2_busy, l2_rdy, mem_req});
            end
        end
        complete = 1'b1;
        tick();
        complete = 1'b0;
        checks++;
        if ({l2_busy, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL first_idle: busy/req=%b expected 00", {l2_busy, mem_req});
        end
        checks++;
        if (l2_rdata !== line_of(a1)) begin
            errors++;
            $display("FAIL rdata_hold_idle: got %h expected %h", l2_rdata, line_of(a1));
        end
        issue_read(a2);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL second_accept: mem_req=%b expected 1", mem_req);
        end
        wait_rdy("second");
        finish_req("second", line_of(a2));
    endtask

    task automatic test_write_error();
        irq         = 1'b1;
        l2_cache_rw = `WRITE;
        l2_addr     = 32'h0000_4440;
        tick();
        irq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({wr_err, l2_busy, mem_req} !== 3'b100) begin
                errors++;
                $display("FAIL write_err_%0d: err/busy/req=%b expected 100", i, {wr_err, l2_busy, mem_req});
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [31:0] held;
        a = 32'h0000_5A44;
        issue_read(a);
        tick();
        ack_allow = 1'b0;
        held = mem_addr;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, held}) begin
                errors++;
                $display("FAIL stall_hold_%0d: req=%b addr=%h expected 1 %h", i, mem_req, mem_addr, held);
            end
            tick();
        end
        ack_allow = 1'b1;
        exp_lat   = 9;
        wait_rdy("stall");
        finish_req("stall", line_of(a));
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] a;
        a = 32'h0000_3000;
        issue_read(a);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_addr_q.delete();
        exp_line_q.delete();
        checks++;
        if ({l2_busy, l2_rdy, mem_req, wr_err} !== 4'b0000) begin
            errors++;
            $display("FAIL midfetch_flags: busy/rdy/req/err=%b expected 0000", {l2_busy, l2_rdy, mem_req, wr_err});
        end
        checks++;
        if (l2_rdata !== 128'd0) begin
            errors++;
            $display("FAIL midfetch_rdata: got %h expected 0", l2_rdata);
        end
        ack_force = 1'b1;
        tick();
        tick();
        ack_force = 1'b0;
        checks++;
        if ({l2_busy, mem_req, l2_rdata} !== 130'd0) begin
            errors++;
            $display("FAIL stray_ack: busy=%b req=%b rdata=%h expected all 0", l2_busy, mem_req, l2_rdata);
        end
        a = 32'h0000_3008;
        issue_read(a);
        wait_rdy("fresh");
        finish_req("fresh", line_of(a));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        accept_cyc  = 0;
        exp_lat     = 6;
        reset       = 1'b1;
        irq         = 1'b0;
        l2_addr     = 32'd0;
        l2_cache_rw = `READ;
        complete    = 1'b0;
        ack_allow   = 1'b1;
        ack_force   = 1'b0;
        test_reset();
        test_read_and_delayed_complete();
        test_write_error();
        test_stall();
        test_reset_mid_fetch();
        tick();
        checks++;
        if ((exp_addr_q.size() != 0) || (exp_line_q.size() != 0)) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d beats and %0d lines left, expected 0",
                     exp_addr_q.size(), exp_line_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l2_icache_resp.md
L2_ICACHE_RESP -- requirements
Module: l2_icache_resp

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL: irq  in  1  icache refill request from L1 controller.
REQ-004 SHALL: l2_addr  in  32  request byte address; [31:4] line, [3:2] word.
REQ-005 SHALL: l2_cache_rw  in  1  request direction, encoded `READ / `WRITE per stddef.h.
REQ-006 SHALL: complete  in  1  L1 signals refill line written into tag/data arrays.
REQ-007 SHALL: l2_busy  out  1  responder occupied.
REQ-008 SHALL: l2_rdy  out  1  one-cycle strobe; l2_rdata valid.
REQ-009 SHALL: l2_rdata  out  128  refill line; word w at bits [32w+31:32w].
REQ-010 SHALL: wr_err  out  1  sticky flag, set by a `WRITE request.
REQ-011 SHALL: mem_req  out  1  memory beat request, held until mem_ack.
REQ-012 SHALL: mem_addr  out  32  beat address {line, beat_word, 2'b00}.
REQ-013 SHALL: mem_ack  in  1  beat accepted; mem_rdata valid same cycle.
REQ-014 SHALL: mem_rdata  in  32  beat read data.

Function
REQ-015 SHALL: FSM states IDLE, FETCH, RDY, WAIT_CMP; IDLE only state with l2_busy=0.
REQ-016 SHALL: IDLE + irq + l2_cache_rw==`READ -> latch l2_addr, clear beat counter, go FETCH; mem_req=1 first cycle of FETCH.
REQ-017 SHALL: IDLE + irq + `WRITE -> set wr_err, stay IDLE, no memory traffic.
REQ-018 SHALL: FETCH issues 4 beats; mem_req/mem_addr stable until mem_ack; each ack stores mem_rdata in line word slot, advances 2-bit beat counter.
REQ-019 SHALL: 4th mem_ack -> RDY next cycle; mem_req=0 in that cycle.
REQ-020 SHALL: RDY lasts exactly one cycle with l2_rdy=1, l2_busy=1; then WAIT_CMP.
REQ-021 SHALL: complete sampled in RDY or WAIT_CMP -> IDLE next cycle; complete ignored in IDLE/FETCH.
REQ-022 SHALL: l2_rdata holds last assembled line until next FETCH starts overwriting.
REQ-023 SHALL: irq while l2_busy=1 ignored; no queuing; earliest new accept is first IDLE cycle.
REQ-024 SHALL: minimum accept-to-l2_rdy latency = 6 cycles with mem_ack tied high (1 latch + 4 beats + 1).
REQ-025 SHALL: l2_addr[1:0] ignored; beat counter wraps 3->0 mod 4.

Reset
REQ-026 SHALL: reset -> IDLE; l2_busy=0, l2_rdy=0, mem_req=0, mem_addr=0, l2_rdata=0, wr_err=0, beat counter=0.
REQ-027 SHALL: reset mid-FETCH drops mem_req at same edge; partial line discarded; later mem_ack ignored.

Configuration
REQ-028 SHALL: macro CRITICAL_WORD_FIRST_EN defined -> first beat word = l2_addr[3:2], following beats wrap ascending (e.g. 2,3,0,1); slot placement by word index unchanged.
REQ-029 SHALL: macro undefined -> beats always word order 0,1,2,3 regardless of l2_addr[3:2].

Verification
REQ-030 SHALL: reset, irq+`READ, l2_addr=0x0000_1238, mem_ack=1, rdata=0xA0..A3 by word -> l2_rdy 6 cycles after accept, l2_rdata=0xA3A2A1A0 packed words 3..0, l2_busy held until complete.
REQ-031 SHALL: CRITICAL_WORD_FIRST_EN, addr 0x0000_1238 -> mem_addr sequence 0x1238,0x123C,0x1230,0x1234; without macro 0x1230,0x1234,0x1238,0x123C.
REQ-032 SHALL: mem_ack withheld 3 cycles on beat 1 -> mem_req/mem_addr stable throughout, l2_rdy delayed by 3 cycles.
REQ-033 SHALL: complete delayed 5 cycles after l2_rdy -> l2_busy=1 for those cycles, second irq in that window ignored, accepted first IDLE cycle.
REQ-034 SHALL: irq+`WRITE in IDLE -> wr_err=1 next cycle, l2_busy=0, mem_req=0; wr_err cleared only by reset.
REQ-035 SHALL: reset asserted after beat 2 ack -> next cycle IDLE, mem_req=0, l2_rdata=0; fresh request completes normally.
